// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch front end.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } if_state_e;
endpackage

// File: rtl/if_fifo.sv
// In-order slot buffer: a slot is allocated with its address at request time and
// filled with the instruction word when the matching response returns.
module if_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_valid,
  output logic [XLEN-1:0] head_addr,
  output logic [XLEN-1:0] head_data,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   pending
);
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d, pending_q, pending_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  addr_d [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];

  // fill_q always points at the oldest allocated-but-unfilled slot, so it never
  // collides with the tail slot being allocated in the same cycle.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    count_d   = count_q;
    pending_d = pending_q;
    filled_d  = filled_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      pending_d = '0;
      filled_d  = '0;
    end else begin
      if (push) begin
        addr_d[tail_q]   = push_addr;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
      end
      if (fill) begin
        data_d[fill_q]   = fill_data;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d   = count_q + CW'(push) - CW'(pop);
      pending_d = pending_q + CW'(push) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      filled_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      filled_q  <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign head_valid = (count_q != '0) && filled_q[head_q];
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign count      = count_q;
  assign pending    = pending_q;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order imem reads, buffers returned words and
// offers them downstream; redirects flush the buffer and drop in-flight responses.
module if_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count, fifo_pending, outstanding;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_live, rsp_fill, rsp_drop, pop;
  logic            head_valid;
  logic [XLEN-1:0] head_addr, head_data;

  // Dropped responses still hold a credit, so they count against DEPTH.
  assign outstanding    = fifo_pending + drop_q;
  assign occupancy      = {1'b0, fifo_count} + {1'b0, drop_q};
  assign imem_req_valid = (state_q == FETCH) && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop       = rsp_live && (drop_q != '0);
  assign rsp_fill       = rsp_live && (drop_q == '0) && !redirect_valid;
  assign pop            = head_valid && instr_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (!enable && !redirect_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d   = redirect_pc & WORD_MASK;
      drop_d = outstanding - CW'(rsp_live);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (req_fire),
    .push_addr  (pc_q),
    .fill       (rsp_fill),
    .fill_data  (imem_rsp_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (fifo_count),
    .pending    (fifo_pending)
  );

  assign instr_valid = head_valid;
  assign instr_data  = head_valid ? head_data : '0;
  assign instr_pc    = head_valid ? head_addr : '0;

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding != '0));
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model answers with the request address as data,
// a scoreboard queue holds the required instruction stream.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset, enable, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_data, instr_pc;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  exp_q[$];
  mreq_t mq[$];
  int    n_tests = 0, n_fail = 0, cyc = 0, n_fire = 0;
  int    lat_fix = 1;
  logic  lat_rand = 1'b0, rdy_rand = 1'b0;

  if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{start + 32'(4 * i), start + 32'(4 * i)});
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    instr_ready = 1'b0;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d instructions left, 0 required", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    instr_ready    = 1'b0;
    #1;
    chk("no req on redirect", 32'(imem_req_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    chk("valid after redirect", 32'(instr_valid), 32'h0);
    instr_ready = 1'b1;
  endtask

  // Memory: drives responses at the falling edge, samples request handshakes later in the cycle.
  initial begin
    int lat, due, last_due;
    last_due       = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #2;
      if (reset) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
        last_due       = 0;
      end else if (imem_req_valid && imem_req_ready) begin
        lat = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{imem_req_addr, due});
        n_fire++;
      end
    end
  end

  // Monitor: every downstream handshake must match the next required instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected instr: pc %h data %h, none required", instr_pc, instr_data);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_data", instr_data, e.data);
        end
      end
    end
  end

  initial begin
    int k, f0, got;
    logic [31:0] wrap_seq [4];
    reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // Reset values
    tick(); tick(); tick();
    chk("rst req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst instr_valid", 32'(instr_valid), 32'h0);
    chk("rst instr_data", instr_data, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);

    // Basic stream from reset
    enable = 1'b1; instr_ready = 1'b1; lat_fix = 1;
    reset = 1'b0;
    expect_seq(32'h0, 4);
    drain("basic stream", 60);

    // Downstream stall holds head and caps requests at DEPTH
    do_reset();
    f0 = n_fire;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (instr_valid) begin
        chk("stall head pc", instr_pc, 32'h0);
        chk("stall head data", instr_data, 32'h0);
      end
    end
    chk("stall request count", 32'(n_fire - f0), 32'd2);
    chk("stall req_valid", 32'(imem_req_valid), 32'h0);
    chk("stall instr_valid", 32'(instr_valid), 32'h1);
    instr_ready = 1'b1;
    expect_seq(32'h0, 5);
    drain("stall resume", 60);

    // Redirect with two responses outstanding in memory
    lat_fix = 4;
    do_reset();
    instr_ready = 1'b1;
    k = 0;
    while (mq.size() < 2 && k < 20) begin tick(); k++; end
    chk("two outstanding", 32'(mq.size()), 32'd2);
    do_redirect(32'h0000_0103);
    expect_seq(32'h0000_0100, 3);
    drain("redirect drop", 80);

    // Redirect in the same cycle a response returns
    lat_fix = 2;
    do_reset();
    instr_ready = 1'b1;
    k = 0;
    while (!imem_rsp_valid && k < 20) begin tick(); k++; end
    chk("rsp at redirect", 32'(imem_rsp_valid), 32'h1);
    do_redirect(32'h0000_0200);
    expect_seq(32'h0000_0200, 3);
    drain("redirect with rsp", 60);

    // Address wrap past the top of memory
    lat_fix = 1;
    do_redirect(32'hFFFF_FFF8);
    wrap_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    foreach (wrap_seq[i]) exp_q.push_back('{wrap_seq[i], wrap_seq[i]});
    drain("wrap", 60);

    // Random memory handshake and latency
    do_reset();
    lat_rand = 1'b1; rdy_rand = 1'b1;
    expect_seq(32'h0, 1000);
    for (int i = 0; i < 1000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    instr_ready = 1'b0;
    got = 1000 - exp_q.size();
    chk("random progress", 32'(got >= 50), 32'h1);
    exp_q.delete();
    lat_rand = 1'b0; rdy_rand = 1'b0; lat_fix = 1;

    // One-cycle reset pulse mid-stream
    do_reset();
    instr_ready = 1'b1;
    expect_seq(32'h0, 100);
    k = 0;
    while (exp_q.size() > 95 && k < 60) begin tick(); k++; end
    chk("pre-reset progress", 32'(exp_q.size() <= 95), 32'h1);
    reset = 1'b1; instr_ready = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("pulse req_valid", 32'(imem_req_valid), 32'h0);
    chk("pulse req_addr", imem_req_addr, 32'h0000_0000);
    chk("pulse instr_valid", 32'(instr_valid), 32'h0);
    chk("pulse instr_data", instr_data, 32'h0);
    chk("pulse instr_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    expect_seq(32'h0, 4);
    drain("restart after pulse", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
